microwave_control: RTL

MICROWAVE_CONTROL -- requirements
Module: microwave_control

---
 rtl/microwave_pkg.sv | 23 ++
 rtl/tick_gen.sv | 46 ++++
 rtl/microwave_control.sv | 137 +++++++++++++
 3 files changed

// File: rtl/microwave_pkg.sv
// -----------------------------------------------------------------------------
// microwave_pkg
// Shared definitions for the microwave controller: FSM state encoding and the
// default countdown / beeper timing used when the top is instantiated without
// overrides.
// -----------------------------------------------------------------------------
package microwave_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COOKING = 2'd1,
        S_PAUSED  = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Clock cycles per countdown second.
    localparam int unsigned DEFAULT_TICK_DIV = 50_000_000;

    // Clock cycles the end-of-cook beeper stays on.
    localparam int unsigned DEFAULT_BEEP_LEN = 100_000_000;

endpackage : microwave_pkg

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Countdown prescaler. Counts 0..TICK_DIV-1 while `run` is high and wraps to
// 0; holds its value while `run` is low so a paused cook resumes the partial
// second. `zero_cnt` restarts the second from 0.
//
// Ports
//   clock    : rising-edge clock
//   clearn   : synchronous active-low reset, clears the count
//   run      : advance the count this cycle
//   zero_cnt : force the count back to 0 (wins over run)
//   tick     : high in the cycle whose edge wraps the count (run && at last)
// -----------------------------------------------------------------------------
module tick_gen
    import microwave_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clock,
    input  logic clearn,
    input  logic run,
    input  logic zero_cnt,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Combinational decode; the consumer registers it into its own output.
    assign tick = run && (cnt == LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement or block ordering.
    always_ff @(posedge clock) begin
        if (!clearn) begin
            cnt <= '0;
        end else if (zero_cnt) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule : tick_gen

// File: rtl/microwave_control.sv
// -----------------------------------------------------------------------------
// microwave_control
// Microwave oven controller. Drives an external mm:ss BCD countdown timer
// (load / clear / enable) from keypad, start, stop and door inputs, switches
// the magnetron, and sounds the beeper when the timer reaches 00:00.
//
// Ports
//   clock        : rising-edge clock
//   clearn       : synchronous active-low reset
//   startn       : active-low start / resume level
//   stopn        : active-low pause / cancel level
//   door_closed  : 1 = door closed
//   key_valid    : one-cycle pulse, keypad digit present on the timer bus
//   timer_zero   : timer reads 00:00
//   timer_loadn  : active-low digit load strobe to the timer
//   timer_clearn : active-low clear to the timer
//   timer_enable : one-cycle countdown strobe to the timer
//   mag_on       : magnetron and lamp drive
//   done         : end-of-cook beeper drive
// -----------------------------------------------------------------------------
module microwave_control
    import microwave_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV,
    parameter int unsigned BEEP_LEN = DEFAULT_BEEP_LEN
) (
    input  logic clock,
    input  logic clearn,
    input  logic startn,
    input  logic stopn,
    input  logic door_closed,
    input  logic key_valid,
    input  logic timer_zero,
    output logic timer_loadn,
    output logic timer_clearn,
    output logic timer_enable,
    output logic mag_on,
    output logic done
);

    localparam int unsigned BEEP_W = (BEEP_LEN > 1) ? $clog2(BEEP_LEN) : 1;
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_LEN - 1);

    state_t            state;
    logic [BEEP_W-1:0] beep_cnt;
    logic              tick;
    logic              pre_run;
    logic              pre_zero;

    // The prescaler only advances in a cycle that stays in COOKING, so a
    // pause or the final second never consumes a partial count.
    assign pre_run  = (state == S_COOKING) && door_closed && stopn && !timer_zero;
    // Every fresh cook starts a whole second; PAUSED keeps the partial one.
    assign pre_zero = (state == S_IDLE) || (state == S_DONE);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clock    (clock),
        .clearn   (clearn),
        .run      (pre_run),
        .zero_cnt (pre_zero),
        .tick     (tick)
    );

    always_ff @(posedge clock) begin
        if (!clearn) begin
            state        <= S_IDLE;
            beep_cnt     <= '0;
            timer_loadn  <= 1'b1;
            timer_clearn <= 1'b0;   // clear the timer together with us
            timer_enable <= 1'b0;
            mag_on       <= 1'b0;
            done         <= 1'b0;
        end else begin
            // NOTE: the strobe outputs get an inactive default here and are
            // overridden below, so each pulse lasts exactly one cycle.
            timer_loadn  <= 1'b1;
            timer_clearn <= 1'b1;
            timer_enable <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (key_valid) begin
                        timer_loadn <= 1'b0;
                    end
                    if (!stopn) begin
                        timer_clearn <= 1'b0;
                    end else if (!startn && door_closed && !timer_zero) begin
                        state  <= S_COOKING;
                        mag_on <= 1'b1;
                    end
                end

                S_COOKING: begin
                    if (timer_zero) begin
                        state    <= S_DONE;
                        mag_on   <= 1'b0;
                        done     <= 1'b1;
                        beep_cnt <= '0;
                    end else if (!door_closed || !stopn) begin
                        state  <= S_PAUSED;
                        mag_on <= 1'b0;
                    end else begin
                        timer_enable <= tick;
                    end
                end

                S_PAUSED: begin
                    if (!stopn) begin
                        state        <= S_IDLE;
                        timer_clearn <= 1'b0;
                    end else if (!startn && door_closed) begin
                        state  <= S_COOKING;
                        mag_on <= 1'b1;
                    end
                end

                S_DONE: begin
                    if (!door_closed || !stopn || (beep_cnt == BEEP_LAST)) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end else begin
                        beep_cnt <= beep_cnt + BEEP_W'(1);
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    mag_on <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule : microwave_control
